// File: rtl/vram_rect_filler.sv
// Rectangle filler: takes one clipped rectangle command and streams one VRAM
// pixel write per clock in raster order, never leaving the visible frame.
//
//  state  | meaning
//  IDLE   | cmd_ready high, waiting for a command
//  CLIP   | one cycle: clip against the frame, seed row/column counters
//  FILL   | one pixel write per cycle in raster order
//  DONE   | one cycle: done pulse, write enable dropped
module vram_rect_filler #(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480
) (
   input  logic        vram_clk,
   input  logic        clr,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [9:0]  cmd_x,
   input  logic [8:0]  cmd_y,
   input  logic [9:0]  cmd_w,
   input  logic [8:0]  cmd_h,
   input  logic [11:0] cmd_color,
   output logic        we,
   output logic [18:0] addr,
   output logic [11:0] data,
   output logic        busy,
   output logic        done
);

   localparam logic [10:0] W11 = 11'(WIDTH);
   localparam logic [9:0]  H10 = 10'(HEIGHT);
   localparam logic [18:0] W19 = 19'(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_CLIP, S_FILL, S_DONE} state_t;

   state_t      state;
   logic [9:0]  x_q;
   logic [8:0]  y_q;
   logic [9:0]  w_q;
   logic [8:0]  h_q;
   logic [11:0] color_q;
   logic [10:0] x_end;
   logic [9:0]  y_end;
   logic [9:0]  cx;
   logic [8:0]  cy;
   logic [18:0] row_base;

   logic [10:0] x_sum;
   logic [9:0]  y_sum;
   logic [10:0] cx_nxt;
   logic [9:0]  cy_nxt;
   logic        empty;

   // One bit wider than the operands so the end coordinates never wrap.
   assign x_sum  = {1'b0, x_q} + {1'b0, w_q};
   assign y_sum  = {1'b0, y_q} + {1'b0, h_q};
   assign cx_nxt = {1'b0, cx} + 11'd1;
   assign cy_nxt = {1'b0, cy} + 10'd1;
   assign empty  = (w_q == 10'd0) || (h_q == 9'd0) ||
                   ({1'b0, x_q} >= W11) || ({1'b0, y_q} >= H10);

   always_ff @(posedge vram_clk) begin
      if (clr) begin
         state     <= S_IDLE;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         we        <= 1'b0;
         addr      <= '0;
         data      <= '0;
         x_q       <= '0;
         y_q       <= '0;
         w_q       <= '0;
         h_q       <= '0;
         color_q   <= '0;
         x_end     <= '0;
         y_end     <= '0;
         cx        <= '0;
         cy        <= '0;
         row_base  <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               we <= 1'b0;
               if (cmd_valid) begin
                  x_q       <= cmd_x;
                  y_q       <= cmd_y;
                  w_q       <= cmd_w;
                  h_q       <= cmd_h;
                  color_q   <= cmd_color;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  state     <= S_CLIP;
               end
            end
            S_CLIP: begin
               x_end    <= (x_sum > W11) ? W11 : x_sum;
               y_end    <= (y_sum > H10) ? H10 : y_sum;
               cx       <= x_q;
               cy       <= y_q;
               // The only multiply: once per command, never inside the fill loop.
               row_base <= 19'(y_q) * W19;
               state    <= empty ? S_DONE : S_FILL;
            end
            S_FILL: begin
               we   <= 1'b1;
               addr <= row_base + 19'(cx);
               data <= color_q;
               if (cx_nxt < x_end) begin
                  cx <= cx + 10'd1;
               end else if (cy_nxt < y_end) begin
                  cx       <= x_q;
                  cy       <= cy + 9'd1;
                  row_base <= row_base + W19;
               end else begin
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               we        <= 1'b0;
               done      <= 1'b1;
               busy      <= 1'b0;
               cmd_ready <= 1'b1;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
